// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: valid/ready handshake, optional 2-entry skid buffer,
// write-enable qualification and registered writeback-data mux.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter bit SKID   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] Memdata_i,
    input  logic [RD_W-1:0]   RDaddr_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [DATA_W-1:0] ALUResult_o,
    output logic [DATA_W-1:0] Memdata_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic [RD_W-1:0]   RDaddr_o,
    output logic              fwd_valid_o,
    output logic [1:0]        occupancy_o
);
    localparam int ENT_W = 2 + 3 * DATA_W + RD_W;

    logic [ENT_W-1:0]  in_entry;
    logic [ENT_W-1:0]  head_reg;
    logic [ENT_W-1:0]  skid_reg;
    logic              head_valid_reg;
    logic              skid_valid_reg;
    logic              head_regwrite;
    logic              in_regwrite;
    logic [DATA_W-1:0] in_wbdata;
    logic              in_xfer;
    logic              out_xfer;

    // Writes to x0 are squashed once here so the forwarding path never sees them.
    assign in_regwrite = RegWrite_i & (RDaddr_i != '0);
    assign in_wbdata   = MemtoReg_i ? Memdata_i : ALUResult_i;
    assign in_entry    = {in_regwrite, MemtoReg_i, ALUResult_i, Memdata_i, in_wbdata, RDaddr_i};

    generate
        if (SKID) begin : g_skid
            // Full only when the skid slot is taken; no path from ready_i.
            assign ready_o = ~rst_i & ~skid_valid_reg;
        end else begin : g_single
            assign ready_o = ~rst_i & (~head_valid_reg | ready_i);
        end
    endgenerate

    assign in_xfer  = valid_i & ready_o & ~flush_i;
    assign out_xfer = head_valid_reg & ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            head_reg       <= '0;
            skid_reg       <= '0;
        end else if (flush_i) begin
            head_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (!head_valid_reg) begin
            if (in_xfer) begin
                head_reg       <= in_entry;
                head_valid_reg <= 1'b1;
            end
        end else if (!skid_valid_reg) begin
            // Single-entry build never takes the skid branch: in_xfer implies out_xfer there.
            if (in_xfer && out_xfer) begin
                head_reg <= in_entry;
            end else if (in_xfer) begin
                skid_reg       <= in_entry;
                skid_valid_reg <= 1'b1;
            end else if (out_xfer) begin
                head_valid_reg <= 1'b0;
            end
        end else if (out_xfer) begin
            head_reg       <= skid_reg;
            skid_valid_reg <= 1'b0;
        end
    end

    assign {head_regwrite, MemtoReg_o, ALUResult_o, Memdata_o, WBdata_o, RDaddr_o} = head_reg;

    assign valid_o     = head_valid_reg;
    assign RegWrite_o  = head_valid_reg & head_regwrite;
    assign fwd_valid_o = RegWrite_o;
    assign occupancy_o = {skid_valid_reg, head_valid_reg & ~skid_valid_reg};

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_mem_wb_stage;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int VW = 4 + 3 * DW + RW + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, flush, valid_i, ready_i, rw_i, m2r_i;
    logic [DW-1:0] alu_i, mem_i;
    logic [RW-1:0] rd_i;
    logic          valid_o, ready_o, rw_o, m2r_o, fwd_o;
    logic [DW-1:0] alu_o, mem_o, wb_o;
    logic [RW-1:0] rd_o;
    logic [1:0]    occ_o;
    logic          v0, rdy0;
    logic          valid0_o, ready0_o, rw0_o, m2r0_o, fwd0_o;
    logic [DW-1:0] alu0_o, mem0_o, wb0_o;
    logic [RW-1:0] rd0_o;
    logic [1:0]    occ0_o;

    mem_wb_stage #(.DATA_W(DW), .RD_W(RW), .SKID(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid_i), .ready_o(ready_o),
        .RegWrite_i(rw_i), .MemtoReg_i(m2r_i), .ALUResult_i(alu_i), .Memdata_i(mem_i),
        .RDaddr_i(rd_i), .valid_o(valid_o), .ready_i(ready_i), .RegWrite_o(rw_o),
        .MemtoReg_o(m2r_o), .ALUResult_o(alu_o), .Memdata_o(mem_o), .WBdata_o(wb_o),
        .RDaddr_o(rd_o), .fwd_valid_o(fwd_o), .occupancy_o(occ_o)
    );

    mem_wb_stage #(.DATA_W(DW), .RD_W(RW), .SKID(1'b0)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(v0), .ready_o(ready0_o),
        .RegWrite_i(rw_i), .MemtoReg_i(m2r_i), .ALUResult_i(alu_i), .Memdata_i(mem_i),
        .RDaddr_i(rd_i), .valid_o(valid0_o), .ready_i(rdy0), .RegWrite_o(rw0_o),
        .MemtoReg_o(m2r0_o), .ALUResult_o(alu0_o), .Memdata_o(mem0_o), .WBdata_o(wb0_o),
        .RDaddr_o(rd0_o), .fwd_valid_o(fwd0_o), .occupancy_o(occ0_o)
    );

    logic [VW-1:0] dut_vec;
    assign dut_vec = {valid_o, ready_o, rw_o, m2r_o, alu_o, mem_o, wb_o, rd_o, fwd_o, occ_o};

    typedef struct packed {
        logic          rw;
        logic          m2r;
        logic [DW-1:0] alu;
        logic [DW-1:0] mem;
        logic [RW-1:0] rd;
    } beat_t;

    beat_t q[$];
    bit    data_zero = 1'b0;
    int    n_cmp = 0;
    int    n_fail = 0;

    // Advance one clock and update the reference FIFO (capacity 2) from the driven inputs.
    task automatic tick();
        bit    vin, vout;
        beat_t b;
        vout = (q.size() > 0) && ready_i;
        vin  = valid_i && !rst && (q.size() < 2) && !flush;
        b.rw = rw_i; b.m2r = m2r_i; b.alu = alu_i; b.mem = mem_i; b.rd = rd_i;
        @(posedge clk);
        if (rst) begin
            q.delete();
            data_zero = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (vout) begin
                $display("xfer out: rd=%0d wb=%h", q[0].rd, q[0].m2r ? q[0].mem : q[0].alu);
                void'(q.pop_front());
            end
            if (vin) begin
                q.push_back(b);
                data_zero = 1'b0;
            end
        end
        #1;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [DW-1:0] alu, mem, wb;
        logic [RW-1:0] rd;
        logic          v, rw, m2r;
        logic [1:0]    occ;
        v = (q.size() > 0);
        alu = '0; mem = '0; wb = '0; rd = '0; rw = 1'b0; m2r = 1'b0;
        if (v) begin
            alu = q[0].alu; mem = q[0].mem; m2r = q[0].m2r; rd = q[0].rd;
            wb  = m2r ? mem : alu;
            rw  = q[0].rw && (rd != 0);
        end
        occ = 2'(q.size());
        return {v, (!rst && q.size() < 2), rw, m2r, alu, mem, wb, rd, rw, occ};
    endfunction

    // Data fields are don't-care on an empty stage unless reset has just cleared them.
    function automatic logic [VW-1:0] exp_mask();
        logic dk;
        dk = (q.size() > 0) || data_zero;
        return {3'b111, {(1 + 3 * DW + RW){dk}}, 3'b111};
    endfunction

    task automatic set_beat(input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                            input logic m2r, input logic rw, input logic [RW-1:0] rd);
        alu_i = alu; mem_i = mem; m2r_i = m2r; rw_i = rw; rd_i = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b1; set_beat(32'h99, 32'h0, 1'b0, 1'b1, 5'd4);
        tick();
        n_cmp++;
        if ((dut_vec & exp_mask()) !== (exp_vec() & exp_mask()) || ready_o !== 1'b0 || wb_o !== '0) begin
            n_fail++;
            $display("FAIL reset: got %h required %h", dut_vec, exp_vec());
        end
        rst = 1'b0; valid_i = 1'b0;
        #1;
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || occ_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b valid=%b occ=%0d required 1 0 0", ready_o, valid_o, occ_o);
        end
        tick();
    endtask

    task automatic test_stream();
        logic [DW-1:0] vals [3];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; set_beat(vals[i], 32'hFFFF_0000, 1'b0, 1'b1, 5'd3);
            tick();
            n_cmp++;
            if (wb_o !== vals[i] || occ_o > 2'd1 || ready_o !== 1'b1 ||
                (dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                n_fail++;
                $display("FAIL stream[%0d]: wb=%h occ=%0d ready=%b required wb=%h", i, wb_o, occ_o, ready_o, vals[i]);
            end
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_wb [6];
        logic [1:0]    exp_occ [6];
        logic          vin [6];
        logic          rdy [6];
        logic [DW-1:0] dat [6];
        exp_wb  = '{32'hA1, 32'hA1, 32'hA1, 32'hB2, 32'hC3, 32'hC3};
        exp_occ = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
        vin     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rdy     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        dat     = '{32'hA1, 32'hB2, 32'hC3, 32'hC3, 32'hC3, 32'h0};
        for (int i = 0; i < 6; i++) begin
            valid_i = vin[i]; ready_i = rdy[i]; set_beat(dat[i], 32'h0, 1'b0, 1'b1, 5'd2);
            tick();
            n_cmp++;
            if (occ_o !== exp_occ[i] || (exp_occ[i] != 0 && wb_o !== exp_wb[i]) ||
                ready_o !== (exp_occ[i] != 2'd2) ||
                (dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: wb=%h occ=%0d ready=%b required wb=%h occ=%0d",
                         i, wb_o, occ_o, ready_o, exp_wb[i], exp_occ[i]);
            end
        end
    endtask

    task automatic test_mux_qual();
        logic [DW-1:0] alu [3];
        logic [DW-1:0] mem [3];
        logic          m2r [3];
        logic [RW-1:0] rd [3];
        logic [DW-1:0] ewb [3];
        logic          erw [3];
        alu = '{32'h5, 32'h1234, 32'h77};
        mem = '{32'hDEADBEEF, 32'h0, 32'h0};
        m2r = '{1'b1, 1'b0, 1'b0};
        rd  = '{5'd9, 5'd0, 5'd7};
        ewb = '{32'hDEADBEEF, 32'h1234, 32'h77};
        erw = '{1'b1, 1'b0, 1'b1};
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; set_beat(alu[i], mem[i], m2r[i], 1'b1, rd[i]);
            tick();
            n_cmp++;
            if (wb_o !== ewb[i] || rw_o !== erw[i] || fwd_o !== erw[i] || rd_o !== rd[i] ||
                (dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                n_fail++;
                $display("FAIL mux_qual[%0d]: wb=%h rw=%b fwd=%b rd=%0d required wb=%h rw=%b rd=%0d",
                         i, wb_o, rw_o, fwd_o, rd_o, ewb[i], erw[i], rd[i]);
            end
        end
        valid_i = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        ready_i = 1'b0; valid_i = 1'b1;
        set_beat(32'h101, 32'h0, 1'b0, 1'b1, 5'd1); tick();
        set_beat(32'h202, 32'h0, 1'b0, 1'b1, 5'd1); tick();
        flush = 1'b1; set_beat(32'hBAD, 32'h0, 1'b0, 1'b1, 5'd1);
        tick();
        flush = 1'b0;
        n_cmp++;
        if (valid_o !== 1'b0 || occ_o !== 2'd0 || ready_o !== 1'b1 || rw_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: valid=%b occ=%0d ready=%b required 0 0 1", valid_o, occ_o, ready_o);
        end
        ready_i = 1'b1; set_beat(32'h600D, 32'h0, 1'b0, 1'b1, 5'd1);
        tick();
        valid_i = 1'b0;
        n_cmp++;
        if (wb_o !== 32'h600D || occ_o !== 2'd1 || (dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
            n_fail++;
            $display("FAIL flush_drop: wb=%h occ=%0d required wb=600d occ=1", wb_o, occ_o);
        end
        tick();
    endtask

    task automatic test_reset_full();
        ready_i = 1'b0; valid_i = 1'b1;
        set_beat(32'h303, 32'h404, 1'b1, 1'b1, 5'd5); tick();
        set_beat(32'h505, 32'h606, 1'b1, 1'b1, 5'd6); tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (dut_vec !== '0 || (dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
            n_fail++;
            $display("FAIL reset_full: got %h required all zero", dut_vec);
        end
        rst = 1'b0; ready_i = 1'b1; set_beat(32'h77, 32'h0, 1'b0, 1'b1, 5'd8);
        #1;
        n_cmp++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_full_ready: ready=%b required 1", ready_o);
        end
        tick();
        valid_i = 1'b0;
        n_cmp++;
        if (wb_o !== 32'h77 || valid_o !== 1'b1 || rw_o !== 1'b1 || rd_o !== 5'd8) begin
            n_fail++;
            $display("FAIL reset_full_capture: wb=%h valid=%b rw=%b rd=%0d required 77 1 1 8", wb_o, valid_o, rw_o, rd_o);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 19) == 0);
            set_beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     RW'($urandom_range(0, 31)));
            tick();
            n_cmp++;
            if ((dut_vec & exp_mask()) !== (exp_vec() & exp_mask())) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h required %h", i, dut_vec & exp_mask(), exp_vec() & exp_mask());
            end
        end
        flush = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_skid0();
        valid_i = 1'b0; ready_i = 1'b1;
        v0 = 1'b1; rdy0 = 1'b0; set_beat(32'hA, 32'h0, 1'b0, 1'b1, 5'd3);
        tick();
        n_cmp++;
        if (valid0_o !== 1'b1 || wb0_o !== 32'hA || ready0_o !== 1'b0) begin
            n_fail++;
            $display("FAIL skid0_hold: valid=%b wb=%h ready=%b required 1 a 0", valid0_o, wb0_o, ready0_o);
        end
        set_beat(32'hB, 32'h0, 1'b0, 1'b1, 5'd3);
        tick();
        n_cmp++;
        if (wb0_o !== 32'hA || ready0_o !== 1'b0 || occ0_o !== 2'd1) begin
            n_fail++;
            $display("FAIL skid0_stall: wb=%h ready=%b occ=%0d required a 0 1", wb0_o, ready0_o, occ0_o);
        end
        rdy0 = 1'b1;
        #1;
        n_cmp++;
        if (ready0_o !== 1'b1) begin
            n_fail++;
            $display("FAIL skid0_comb_ready: ready=%b required 1", ready0_o);
        end
        for (int k = 1; k <= 3; k++) begin
            set_beat(DW'(k), 32'h0, 1'b0, 1'b1, 5'd3);
            tick();
            n_cmp++;
            if (wb0_o !== DW'(k) || valid0_o !== 1'b1 || occ0_o !== 2'd1 || ready0_o !== 1'b1) begin
                n_fail++;
                $display("FAIL skid0_stream[%0d]: wb=%h valid=%b occ=%0d required wb=%0h", k, wb0_o, valid0_o, occ0_o, k);
            end
        end
        v0 = 1'b0;
        tick();
        n_cmp++;
        if (valid0_o !== 1'b0 || occ0_o !== 2'd0 || rw0_o !== 1'b0) begin
            n_fail++;
            $display("FAIL skid0_drain: valid=%b occ=%0d required 0 0", valid0_o, occ0_o);
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0; v0 = 1'b0; rdy0 = 1'b0;
        set_beat('0, '0, 1'b0, 1'b0, '0);
        test_reset();
        test_stream();
        test_backpressure();
        test_mux_qual();
        test_flush();
        test_reset_full();
        test_random();
        test_skid0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
- Adds flush, back-pressure, write-enable qualification and a registered writeback-data mux over the earlier always-load stage register.
- Sits between the data-memory stage and the register-file write port.
- Exposes its head entry for EX-stage forwarding.

Parameters:
- DATA_W, 32, width of ALU result, memory data and writeback data.
- RD_W, 5, width of destination register address.
- SKID, 1, 1 = 2-entry skid buffer (ready_o registered); 0 = single entry (ready_o combinational).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  discard all held and incoming entries.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage can accept an entry this cycle.
- RegWrite_i  in  1  entry writes the register file.
- MemtoReg_i  in  1  1 = writeback selects Memdata_i, 0 = ALUResult_i.
- ALUResult_i  in  DATA_W  ALU result.
- Memdata_i  in  DATA_W  load data.
- RDaddr_i  in  RD_W  destination register.
- valid_o  out  1  head entry valid.
- ready_i  in  1  downstream accepts head entry.
- RegWrite_o  out  1  qualified write enable of head entry.
- MemtoReg_o  out  1  head MemtoReg.
- ALUResult_o  out  DATA_W  head ALU result.
- Memdata_o  out  DATA_W  head memory data.
- WBdata_o  out  DATA_W  head writeback data (mux result).
- RDaddr_o  out  RD_W  head destination.
- fwd_valid_o  out  1  head entry is a forwarding candidate.
- occupancy_o  out  2  number of held entries (0..2).

Behaviour:
- Reset and clocking:
  - One clock, clk_i.
  - Reset is synchronous and active-high on rst_i.
  - While rst_i is sampled high, both entries are cleared at the edge; all data/control registers go to 0.
  - After reset: valid_o=0, RegWrite_o=0, MemtoReg_o=0, ALUResult_o=Memdata_o=WBdata_o=0, RDaddr_o=0, fwd_valid_o=0, occupancy_o=0.
  - ready_o is forced 0 while rst_i is high and is 1 on the first cycle after reset deasserts.
- Handshakes:
  - Input transfer (in_xfer) = valid_i & ready_o & ~flush_i.
  - Output transfer (out_xfer) = valid_o & ready_i.
- Capture rules:
  - RegWrite is qualified on capture: stored value = RegWrite_i & (RDaddr_i != 0).
  - WBdata is computed on capture: MemtoReg_i ? Memdata_i : ALUResult_i. It is stored as a register, not muxed on the output path.
- Storage (SKID=1): head entry H (drives outputs) and skid entry S. States by occupancy:
  - EMPTY (0): in_xfer loads H; go to ONE.
  - ONE (1):
    - in_xfer & out_xfer: H <= input, stay ONE.
    - in_xfer only: S <= input, go to FULL.
    - out_xfer only: go to EMPTY.
  - FULL (2):
    - out_xfer: H <= S, go to ONE.
    - in_xfer cannot occur in FULL.
- ready_o:
  - SKID=1: ready_o = (occupancy != 2), derived from registered state; no combinational path from ready_i.
  - SKID=0: only H exists; ready_o = ~valid_o | ready_i (combinational). in_xfer with out_xfer replaces H in place.
- Head entry and forwarding:
  - Data stays stable on the outputs while valid_o=1 and ready_i=0. Order is strictly FIFO.
  - RegWrite_o = valid_o & stored RegWrite, so it is never asserted for an invalid head.
  - fwd_valid_o = RegWrite_o. Consumers compare RDaddr_o and use WBdata_o.
- flush_i:
  - At the edge, occupancy becomes 0 and valid_o=0.
  - The same-cycle input beat is dropped even if valid_i=1.
  - Data registers need not clear; the valid bits gate everything.
  - flush_i has priority over in_xfer and out_xfer.
  - rst_i has priority over flush_i.
- Reset mid-operation: identical to flush, plus the data registers clear to 0.
- Data registers load only on their transfer events; there is no free-running load.

Test Plan:
- Reset then stream with ready_i=1: send ALUResult_i=0x11,0x22,0x33 with MemtoReg_i=0 on consecutive cycles.
  - -> WBdata_o=0x11,0x22,0x33 one cycle after each input.
  - -> occupancy_o stays ≤1, ready_o stays 1.
- Back-pressure: hold ready_i=0, send 3 beats (A,B,C).
  - -> A and B are accepted.
  - -> ready_o=0 after B is captured, so C stalls upstream; occupancy_o=2.
  - -> outputs stay A until ready_i=1, then drain in order A, B, C with no loss or duplication.
- Mux and qualification cases:
  - MemtoReg_i=1, Memdata_i=0xDEADBEEF, ALUResult_i=0x5 -> WBdata_o=0xDEADBEEF.
  - RegWrite_i=1, RDaddr_i=0 -> RegWrite_o=0, fwd_valid_o=0.
  - RegWrite_i=1, RDaddr_i=7 -> RegWrite_o=1, RDaddr_o=7.
- Flush with occupancy_o=2 and valid_i=1 in the same cycle.
  - -> next cycle: valid_o=0, occupancy_o=0, ready_o=1.
  - -> the dropped beat never appears at the output.
- Synchronous reset asserted for one cycle while FULL.
  - -> all outputs 0 and ready_o=0 during that cycle.
  - -> a beat sent on the first post-reset cycle is captured normally.
- SKID=0 build:
  - ready_i=0 with H valid -> ready_o=0.
  - ready_i=1 and valid_i=1 -> H is replaced each cycle at full throughput (0x1,0x2,0x3 back-to-back).
